// File: rtl/uart_cmd_decoder_if.sv
// ============================================================================
//  Module      : uart_cmd_decoder_if
//  Description : Byte-in / command-out bundle between the UART byte receiver,
//                the command decoder and the sensor controller.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_cmd_decoder_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [7:0] cmd_code;
    logic [7:0] cmd_addr;
    logic       err_valid;
    logic [2:0] err_code;
    logic       busy;

    // Decoder side: consumes bytes, produces commands and error strobes.
    modport master (
        input  rx_data, rx_valid, cmd_ready,
        output cmd_valid, cmd_code, cmd_addr, err_valid, err_code, busy
    );

    // Environment side: receiver plus sensor controller.
    modport slave (
        output rx_data, rx_valid, cmd_ready,
        input  cmd_valid, cmd_code, cmd_addr, err_valid, err_code, busy
    );
endinterface

`default_nettype wire

// File: rtl/uart_cmd_decoder.sv
// ============================================================================
//  Module      : uart_cmd_decoder
//  Description : Assembles 2-byte host commands (code, sensor address) from
//                the UART byte stream, validates them, presents them on a
//                valid/ready handshake and strobes error codes.
//                Optional build macro CMD_CHECKSUM_EN adds a third checksum
//                byte (code XOR addr) per command.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_cmd_decoder #(
    parameter int TIMEOUT_CYCLES = 11520,
    parameter int MAX_ADDR       = 31,
    parameter int NUM_CMDS       = 5
) (
    input  wire logic          clk_115200hz,
    input  wire logic          rst,
    uart_cmd_decoder_if.master bus
);

    localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [7:0]         c_NUM_CMDS = 8'(NUM_CMDS);
    localparam logic [7:0]         c_MAX_ADDR = 8'(MAX_ADDR);

    localparam logic [2:0] c_ERR_BAD_CMD  = 3'd1;
    localparam logic [2:0] c_ERR_BAD_ADDR = 3'd2;
    localparam logic [2:0] c_ERR_TIMEOUT  = 3'd3;
    localparam logic [2:0] c_ERR_OVERRUN  = 3'd4;
`ifdef CMD_CHECKSUM_EN
    localparam logic [2:0] c_ERR_CHECKSUM = 3'd5;
`endif

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ADDR = 2'd1,
        ST_ISSUE     = 2'd2
`ifdef CMD_CHECKSUM_EN
        , ST_WAIT_CHK = 2'd3
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic               rx_valid_q;
    logic               cmd_valid_q, cmd_valid_d;
    logic [7:0]         cmd_code_q, cmd_code_d;
    logic [7:0]         cmd_addr_q, cmd_addr_d;
    logic               err_valid_q, err_valid_d;
    logic [2:0]         err_code_q, err_code_d;
    logic               busy_q, busy_d;
    logic               w_accept;
    logic               w_take_new;

    // A byte counts only on the rising edge of the receiver's level signal.
    assign w_accept = bus.rx_valid & ~rx_valid_q;

    // Next-state and output computation for the command assembler.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_valid_d = cmd_valid_q;
        cmd_code_d  = cmd_code_q;
        cmd_addr_d  = cmd_addr_q;
        err_valid_d = 1'b0;
        err_code_d  = err_code_q;
        w_take_new  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                w_take_new = w_accept;
            end

            ST_WAIT_ADDR: begin
                if (w_accept) begin
                    if (bus.rx_data <= c_MAX_ADDR) begin
                        cmd_addr_d = bus.rx_data;
`ifdef CMD_CHECKSUM_EN
                        cnt_d   = '0;
                        state_d = ST_WAIT_CHK;
`else
                        cmd_valid_d = 1'b1;
                        state_d     = ST_ISSUE;
`endif
                    end else begin
                        err_valid_d = 1'b1;
                        err_code_d  = c_ERR_BAD_ADDR;
                        state_d     = ST_IDLE;
                    end
                end else if (cnt_q == c_CNT_LAST) begin
                    err_valid_d = 1'b1;
                    err_code_d  = c_ERR_TIMEOUT;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end

`ifdef CMD_CHECKSUM_EN
            ST_WAIT_CHK: begin
                if (w_accept) begin
                    if (bus.rx_data == (cmd_code_q ^ cmd_addr_q)) begin
                        cmd_valid_d = 1'b1;
                        state_d     = ST_ISSUE;
                    end else begin
                        err_valid_d = 1'b1;
                        err_code_d  = c_ERR_CHECKSUM;
                        state_d     = ST_IDLE;
                    end
                end else if (cnt_q == c_CNT_LAST) begin
                    err_valid_d = 1'b1;
                    err_code_d  = c_ERR_TIMEOUT;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
`endif

            ST_ISSUE: begin
                if (bus.cmd_ready) begin
                    // Handshake edge; a byte arriving now starts a new command.
                    cmd_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                    w_take_new  = w_accept;
                end else if (w_accept) begin
                    // Pending command is kept; the extra byte is dropped.
                    err_valid_d = 1'b1;
                    err_code_d  = c_ERR_OVERRUN;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Command-code byte handling shared by IDLE and the handshake edge.
        if (w_take_new) begin
            if (bus.rx_data < c_NUM_CMDS) begin
                cmd_code_d = bus.rx_data;
                cnt_d      = '0;
                state_d    = ST_WAIT_ADDR;
            end else begin
                err_valid_d = 1'b1;
                err_code_d  = c_ERR_BAD_CMD;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset discards any partial command.
    always_ff @(posedge clk_115200hz or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rx_valid_q  <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= 8'h00;
            cmd_addr_q  <= 8'h00;
            err_valid_q <= 1'b0;
            err_code_q  <= 3'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_valid_q  <= bus.rx_valid;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
            cmd_addr_q  <= cmd_addr_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_code  = cmd_code_q;
    assign bus.cmd_addr  = cmd_addr_q;
    assign bus.err_valid = err_valid_q;
    assign bus.err_code  = err_code_q;
    assign bus.busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_decoder.sv
// ============================================================================
//  Module      : tb_uart_cmd_decoder
//  Description : Self-checking bench for uart_cmd_decoder: vector table,
//                hand-written corner sequences and randomized traffic
//                against a byte-stream reference model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_cmd_decoder;

    localparam int TO        = 50;
    localparam int MAX_ADDR  = 31;
    localparam int NUM_CMDS  = 5;
`ifdef CMD_CHECKSUM_EN
    localparam int CMD_LEN   = 3;
`else
    localparam int CMD_LEN   = 2;
`endif

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    uart_cmd_decoder_if bus ();

    uart_cmd_decoder #(
        .TIMEOUT_CYCLES (TO),
        .MAX_ADDR       (MAX_ADDR),
        .NUM_CMDS       (NUM_CMDS)
    ) dut (
        .clk_115200hz (clk),
        .rst          (rst),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       v;
        logic       r;
        logic       e_cv;
        logic [7:0] e_code;
        logic [7:0] e_addr;
        logic       e_ev;
        logic [2:0] e_ec;
        logic       e_busy;
    } vec_t;

    vec_t tbl[$];

    // Reference model: partial command bytes, clocks since last byte,
    // pending issued command, last error.
    logic [7:0] m_part[$];
    int         m_gap;
    bit         m_pend;
    logic [7:0] m_code;
    logic [7:0] m_addr;
    bit         m_ev;
    logic [2:0] m_ec;
    bit         m_prev;

    logic [7:0] r_d;
    logic       r_v;
    logic       r_rdy;
    int         gap_left;
    bit         early;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] d, input logic v, input logic r);
        bus.rx_data   = d;
        bus.rx_valid  = v;
        bus.cmd_ready = r;
        tick();
    endtask

    task automatic check(input string name, input bit full, input logic e_cv,
                         input logic [7:0] e_code, input logic [7:0] e_addr,
                         input logic e_ev, input logic [2:0] e_ec, input logic e_busy);
        bit ok;
        n_vec++;
        ok = (bus.cmd_valid === e_cv) && (bus.err_valid === e_ev) &&
             (bus.err_code === e_ec) && (bus.busy === e_busy);
        if (full || e_cv)
            ok = ok && (bus.cmd_code === e_code) && (bus.cmd_addr === e_addr);
        if (!ok) begin
            n_err++;
            $display("FAIL %s @%0t: got cv=%b code=%h addr=%h ev=%b ec=%0d busy=%b, want cv=%b code=%h addr=%h ev=%b ec=%0d busy=%b",
                     name, $time, bus.cmd_valid, bus.cmd_code, bus.cmd_addr, bus.err_valid,
                     bus.err_code, bus.busy, e_cv, e_code, e_addr, e_ev, e_ec, e_busy);
        end
    endtask

    task automatic add(input logic [7:0] d, input logic v, input logic r, input logic cv,
                       input logic [7:0] code, input logic [7:0] addr, input logic ev,
                       input logic [2:0] ec, input logic b);
        vec_t x;
        x.d = d; x.v = v; x.r = r; x.e_cv = cv; x.e_code = code; x.e_addr = addr;
        x.e_ev = ev; x.e_ec = ec; x.e_busy = b;
        tbl.push_back(x);
    endtask

    task automatic raise(input logic [2:0] code);
        m_ev = 1'b1;
        m_ec = code;
    endtask

    task automatic model_reset();
        m_part.delete();
        m_gap = 0; m_pend = 0; m_code = 8'h00; m_addr = 8'h00;
        m_ev = 0; m_ec = 3'd0; m_prev = 0;
    endtask

    // One clock of the byte-stream interpreter, given the inputs seen at the edge.
    task automatic model_step(input logic [7:0] d, input logic v, input logic rdy);
        bit acc;
        bit fresh;
        acc    = v && !m_prev;
        m_prev = v;
        m_ev   = 1'b0;
        fresh  = 1'b0;
        if (m_pend) begin
            if (rdy) begin
                m_pend = 0;
                fresh  = acc;
            end else if (acc) begin
                raise(3'd4);
            end
        end else if (m_part.size() == 0) begin
            fresh = acc;
        end else if (acc) begin
            m_part.push_back(d);
            m_gap = 0;
            if (m_part.size() == 2 && d > MAX_ADDR) begin
                raise(3'd2);
                m_part.delete();
            end else if (m_part.size() == CMD_LEN) begin
                if (CMD_LEN == 3 && d != (m_part[0] ^ m_part[1])) begin
                    raise(3'd5);
                end else begin
                    m_pend = 1;
                    m_code = m_part[0];
                    m_addr = m_part[1];
                end
                m_part.delete();
            end
        end else begin
            m_gap++;
            if (m_gap == TO) begin
                raise(3'd3);
                m_part.delete();
            end
        end
        if (fresh) begin
            if (d < NUM_CMDS) begin
                m_part.push_back(d);
                m_gap = 0;
            end else begin
                raise(3'd1);
            end
        end
    endtask

    function automatic logic [7:0] pick();
        if (m_part.size() == 2 && $urandom_range(0, 3) != 0)
            return m_part[0] ^ m_part[1];
        if (m_part.size() == 1)
            return 8'($urandom_range(0, 36));
        if ($urandom_range(0, 9) == 0)
            return 8'($urandom_range(0, 255));
        return 8'($urandom_range(0, 6));
    endfunction

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        bus.rx_data   = 8'h00;
        bus.rx_valid  = 1'b0;
        bus.cmd_ready = 1'b0;
        tick();
        tick();
        check("reset", 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
        rst = 1'b0;

`ifdef CMD_CHECKSUM_EN
        drive(8'h02, 1, 1); check("chk_code", 0, 0, 0, 0, 0, 3'd0, 1);
        drive(8'h02, 0, 1);
        drive(8'h03, 1, 1); check("chk_addr", 0, 0, 0, 0, 0, 3'd0, 1);
        drive(8'h03, 0, 1);
        drive(8'h01, 1, 1); check("chk_ok", 0, 1, 8'h02, 8'h03, 0, 3'd0, 1);
        drive(8'h01, 0, 1); check("chk_ok_hs", 0, 0, 0, 0, 0, 3'd0, 0);
        drive(8'h02, 1, 1);
        drive(8'h02, 0, 1);
        drive(8'h03, 1, 1);
        drive(8'h03, 0, 1);
        drive(8'h00, 1, 1); check("chk_bad", 0, 0, 0, 0, 1, 3'd5, 0);
        drive(8'h00, 0, 1); check("chk_bad_drop", 0, 0, 0, 0, 0, 3'd5, 0);
`else
        //   d      v  r   cv code   addr   ev ec    busy
        add(8'h01, 1, 1,  0, 8'h00, 8'h00, 0, 3'd0, 1);
        add(8'h01, 0, 1,  0, 8'h00, 8'h00, 0, 3'd0, 1);
        add(8'h05, 1, 1,  1, 8'h01, 8'h05, 0, 3'd0, 1);
        add(8'h05, 0, 1,  0, 8'h00, 8'h00, 0, 3'd0, 0);
        add(8'h07, 1, 1,  0, 8'h00, 8'h00, 1, 3'd1, 0);
        add(8'h07, 0, 1,  0, 8'h00, 8'h00, 0, 3'd1, 0);
        add(8'h01, 1, 1,  0, 8'h00, 8'h00, 0, 3'd1, 1);
        add(8'h01, 0, 1,  0, 8'h00, 8'h00, 0, 3'd1, 1);
        add(8'h20, 1, 1,  0, 8'h00, 8'h00, 1, 3'd2, 0);
        add(8'h20, 0, 1,  0, 8'h00, 8'h00, 0, 3'd2, 0);
        add(8'h03, 1, 0,  0, 8'h00, 8'h00, 0, 3'd2, 1);
        add(8'h03, 0, 0,  0, 8'h00, 8'h00, 0, 3'd2, 1);
        add(8'h01, 1, 0,  1, 8'h03, 8'h01, 0, 3'd2, 1);
        add(8'h01, 0, 0,  1, 8'h03, 8'h01, 0, 3'd2, 1);
        add(8'h04, 1, 0,  1, 8'h03, 8'h01, 1, 3'd4, 1);
        add(8'h04, 0, 0,  1, 8'h03, 8'h01, 0, 3'd4, 1);
        add(8'h00, 0, 1,  0, 8'h00, 8'h00, 0, 3'd4, 0);
        add(8'h02, 1, 0,  0, 8'h00, 8'h00, 0, 3'd4, 1);
        add(8'h02, 0, 0,  0, 8'h00, 8'h00, 0, 3'd4, 1);
        add(8'h1F, 1, 0,  1, 8'h02, 8'h1F, 0, 3'd4, 1);
        add(8'h1F, 0, 0,  1, 8'h02, 8'h1F, 0, 3'd4, 1);
        add(8'h04, 1, 1,  0, 8'h00, 8'h00, 0, 3'd4, 1);
        add(8'h04, 0, 1,  0, 8'h00, 8'h00, 0, 3'd4, 1);
        add(8'h00, 1, 1,  1, 8'h04, 8'h00, 0, 3'd4, 1);
        add(8'h00, 0, 1,  0, 8'h00, 8'h00, 0, 3'd4, 0);
        for (int i = 0; i < 10; i++)
            add(8'h02, 1, 1, 0, 8'h00, 8'h00, 0, 3'd4, 1);
        add(8'h02, 0, 1,  0, 8'h00, 8'h00, 0, 3'd4, 1);
        add(8'h05, 1, 1,  1, 8'h02, 8'h05, 0, 3'd4, 1);
        add(8'h05, 0, 1,  0, 8'h00, 8'h00, 0, 3'd4, 0);
        add(8'h05, 1, 1,  0, 8'h00, 8'h00, 1, 3'd1, 0);
        add(8'h05, 0, 1,  0, 8'h00, 8'h00, 0, 3'd1, 0);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].d, tbl[i].v, tbl[i].r);
            check($sformatf("tbl[%0d]", i), 1'b0, tbl[i].e_cv, tbl[i].e_code,
                  tbl[i].e_addr, tbl[i].e_ev, tbl[i].e_ec, tbl[i].e_busy);
        end
`endif

        // Timeout exactly TO clocks after the code byte edge.
        drive(8'h00, 1, 1);
        bus.rx_valid = 1'b0;
        early = 1'b0;
        for (int k = 1; k < TO; k++) begin
            tick();
            if (bus.err_valid !== 1'b0 || bus.busy !== 1'b1) early = 1'b1;
        end
        n_vec++;
        if (early) begin
            n_err++;
            $display("FAIL timeout_early: got error or idle before clock %0d, want busy and quiet", TO);
        end
        tick();
        check("timeout", 0, 0, 0, 0, 1, 3'd3, 0);
        tick();
        check("timeout_drop", 0, 0, 0, 0, 0, 3'd3, 0);

        // Address byte on the timeout edge wins.
        drive(8'h01, 1, 1);
        bus.rx_valid = 1'b0;
        for (int k = 1; k < TO; k++) tick();
        drive(8'h05, 1, 1);
`ifdef CMD_CHECKSUM_EN
        check("late_addr", 0, 0, 0, 0, 0, 3'd3, 1);
        drive(8'h05, 0, 1);
        drive(8'h04, 1, 1);
        check("late_chk", 0, 1, 8'h01, 8'h05, 0, 3'd3, 1);
`else
        check("late_addr", 0, 1, 8'h01, 8'h05, 0, 3'd3, 1);
`endif
        drive(8'h00, 0, 1);
        check("late_hs", 0, 0, 0, 0, 0, 3'd3, 0);

        // Asynchronous reset in WAIT_ADDR.
        drive(8'h02, 1, 1);
        drive(8'h02, 0, 1);
        check("pre_rst", 0, 0, 0, 0, 0, 3'd3, 1);
        #2 rst = 1'b1;
        #1 check("async_rst", 1, 0, 8'h00, 8'h00, 0, 3'd0, 0);
        rst = 1'b0;
        drive(8'h05, 1, 1);
        check("post_rst", 0, 0, 0, 0, 1, 3'd1, 0);
        drive(8'h05, 0, 1);

        // Randomized traffic against the model.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        r_d = 8'h00; r_v = 1'b0; r_rdy = 1'b0; gap_left = 0;
        for (int c = 0; c < 4000; c++) begin
            if (gap_left > 0) begin
                gap_left--;
                r_v = 1'b0;
            end else if (r_v) begin
                r_v = ($urandom_range(0, 2) == 0);
            end else if ($urandom_range(0, 29) == 0) begin
                gap_left = $urandom_range(TO - 5, TO + 5);
            end else if ($urandom_range(0, 1) == 1) begin
                r_v = 1'b1;
                r_d = pick();
            end
            r_rdy = ($urandom_range(0, 3) != 0);
            bus.rx_data   = r_d;
            bus.rx_valid  = r_v;
            bus.cmd_ready = r_rdy;
            model_step(r_d, r_v, r_rdy);
            tick();
            check("rand", 0, m_pend, m_code, m_addr, m_ev, m_ec,
                  m_pend || (m_part.size() > 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
- Sits directly downstream of the UART byte receiver, in the same clk_115200hz domain.
- Consumes received bytes through rx_data/rx_valid and assembles 2-byte host commands: command code, then sensor address.
- Validates each command and presents it to the sensor controller over a valid/ready handshake.
- Reports malformed, incomplete, timed-out and dropped commands on a one-cycle error strobe.

Parameters:
- TIMEOUT_CYCLES, 11520: maximum clocks between bytes of one command (100 ms at 115200 Hz).
- MAX_ADDR, 31: highest legal sensor address.
- NUM_CMDS, 5: legal command codes are 0x00..NUM_CMDS-1 (0 status, 1 temp, 2 humidity, 3 cont. temp, 4 cont. humidity).

Ports:
- clk_115200hz  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  byte from receiver; stable while rx_valid high.
- rx_valid  in  1  receiver byte-ready level; may stay high for several cycles.
- cmd_ready  in  1  sensor controller accepts the command.
- cmd_valid  out  1  command presented.
- cmd_code  out  8  validated command code.
- cmd_addr  out  8  validated sensor address.
- err_valid  out  1  one-cycle error strobe.
- err_code  out  3  0 none, 1 bad cmd, 2 bad addr, 3 timeout, 4 overrun, 5 checksum.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset:
  - Async assert forces state IDLE and clears the timeout counter.
  - cmd_valid=0, cmd_code=0, cmd_addr=0, err_valid=0, err_code=0, busy=0, rx_valid_q=0.
- Byte acceptance: a byte is accepted on an edge where rx_valid=1 and rx_valid_q=0 (registered previous value). A held-high rx_valid yields exactly one byte.
- IDLE:
  - On an accepted byte: if byte < NUM_CMDS, latch it as the code, clear the counter and go to WAIT_ADDR.
  - Otherwise pulse err 1 and stay in IDLE.
- WAIT_ADDR:
  - The counter increments each cycle.
  - On an accepted byte with addr <= MAX_ADDR: latch it and go to ISSUE. cmd_valid rises on that same edge, so latency is one clock from the address byte edge.
  - Address > MAX_ADDR: pulse err 2 and go to IDLE.
  - Counter reaching TIMEOUT_CYCLES-1 with no byte: pulse err 3 and go to IDLE.
  - A byte arriving on the timeout edge wins; no timeout is reported.
- ISSUE:
  - cmd_valid, cmd_code and cmd_addr are held stable until an edge with cmd_ready=1. That edge clears cmd_valid and returns to IDLE.
  - A byte accepted while cmd_valid && !cmd_ready is dropped and err 4 is pulsed; the pending command is unaffected.
  - A byte accepted on the same edge as the handshake is treated as a new command byte, using the IDLE rules.
  - No timeout applies in ISSUE.
- err_valid is high for exactly one cycle per error. err_code holds its last value until the next error.
- Reset mid-command discards partial state; no error is reported.

Optional Feature:
- Macro: CMD_CHECKSUM_EN.
- Defined:
  - A third byte, checksum = code XOR addr, is required.
  - A valid address moves to WAIT_CHK instead of ISSUE. WAIT_CHK restarts the counter and applies the same timeout rule (err 3).
  - Checksum match: go to ISSUE. Mismatch: pulse err 5 and go to IDLE.
  - Latency is counted from the checksum byte edge.
- Undefined: WAIT_CHK and err 5 do not exist; 2-byte commands only.

Test Plan:
- rx_data 0x01 then 0x05, rx_valid pulses, cmd_ready=1 -> cmd_valid one cycle after 2nd byte edge, cmd_code=0x01, cmd_addr=0x05, no error.
- rx_valid held high 10 cycles with 0x02 -> exactly one byte accepted, busy=1, state WAIT_ADDR.
- Byte 0x07 -> err_valid 1 cycle, err_code=1, stays IDLE. Byte 0x01 then 0x20 -> err_code=2.
- Byte 0x00 then no input -> err_code=3 exactly TIMEOUT_CYCLES clocks later. Repeat with the address byte on the final cycle -> command issued, no error.
- cmd_ready=0, command 0x03/0x01 pending, extra byte 0x04 -> err_code=4, cmd stays 0x03/0x01. Raise cmd_ready -> cmd_valid drops.
- Assert rst during WAIT_ADDR -> all outputs 0 immediately. With CMD_CHECKSUM_EN: 0x02, 0x03, 0x01 -> issued; 0x02, 0x03, 0x00 -> err_code=5.
